// File: rtl/seg_mux_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan scheduler.
package seg_mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Timer only ever holds reload values below max(dwell, blank).
  function automatic int tmr_w(input int dwell, input int blank);
    int m;
    m = (dwell > blank) ? dwell : blank;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/seg_mux_scheduler_if.sv
// Pattern inputs and display-pin outputs of the scan scheduler.
interface seg_mux_scheduler_if #(
  parameter int NUM_DIGITS = 4
);
  logic                      enable;
  logic [7*NUM_DIGITS-1:0]   digit_seg;
  logic [NUM_DIGITS-1:0]     digit_en;
  logic [6:0]                seg_out;
  logic [NUM_DIGITS-1:0]     sel;
  logic [2:0]                cur_digit;
  logic                      frame_done;

  modport master (
    output enable, digit_seg, digit_en,
    input  seg_out, sel, cur_digit, frame_done
  );

  modport slave (
    input  enable, digit_seg, digit_en,
    output seg_out, sel, cur_digit, frame_done
  );
endinterface

// File: rtl/seg_mux_scheduler_next_enabled_digit.sv
// Rotating-priority search: first enabled digit at or after start, wrapping.
module next_enabled_digit #(
  parameter int NUM_DIGITS = 4,
  parameter int IW         = 2
) (
  input  logic [NUM_DIGITS-1:0] en,
  input  logic [IW-1:0]         start,
  output logic [IW-1:0]         nxt,
  output logic                  any
);

  int          c;
  logic [IW-1:0] ci;

  // Walk offsets high to low so the smallest offset wins.
  always_comb begin
    nxt = start;
    c   = 0;
    ci  = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      c = int'(start) + k;
      if (c >= NUM_DIGITS) c = c - NUM_DIGITS;
      ci = IW'(c);
      if (en[ci]) nxt = ci;
    end
  end

  assign any = |en;

endmodule

// File: rtl/seg_mux_scheduler.sv
// Dwell/blank scan scheduler driving a shared 7-segment bus with one-hot digit selects.
module seg_mux_scheduler
  import seg_mux_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int DWELL_CYCLES   = 50000,
  parameter int BLANK_CYCLES   = 500,
  parameter int SEL_ACTIVE_LOW = 0
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  seg_mux_scheduler_if.slave  bus
);

  localparam int TW = tmr_w(DWELL_CYCLES, BLANK_CYCLES);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [TW-1:0] DWELL_LD = TW'(DWELL_CYCLES - 1);
  localparam logic [TW-1:0] BLANK_LD = (BLANK_CYCLES > 0) ? TW'(BLANK_CYCLES - 1) : '0;
  localparam logic [NUM_DIGITS-1:0] SEL_OFF = (SEL_ACTIVE_LOW != 0) ? '1 : '0;

  state_t                state, state_n;
  logic [IW-1:0]         idx, idx_n, idx_inc, start, nxt;
  logic                  any;
  logic [TW-1:0]         timer, timer_n;
  logic [6:0]            seg_q, seg_n;
  logic [NUM_DIGITS-1:0] sel_q, sel_n, sel_hot;
  logic [2:0]            cur_q, cur_n;
  logic                  fd_q, fd_n;
  logic [6:0]            seg_arr [NUM_DIGITS];

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_unpack
    assign seg_arr[g] = bus.digit_seg[7*g +: 7];
  end

  assign idx_inc = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
  // At dwell end the search starts past the digit just shown.
  assign start   = (state == ST_DRIVE) ? idx_inc : idx;
  assign sel_hot = NUM_DIGITS'(1) << nxt;

  next_enabled_digit #(.NUM_DIGITS(NUM_DIGITS), .IW(IW)) u_find (
    .en    (bus.digit_en),
    .start (start),
    .nxt   (nxt),
    .any   (any)
  );

  always_comb begin
    state_n = state;
    idx_n   = idx;
    timer_n = timer;
    seg_n   = SEG_BLANK;
    sel_n   = SEL_OFF;
    cur_n   = '0;
    fd_n    = 1'b0;
    case (state)
      ST_IDLE: begin
        idx_n   = '0;
        timer_n = '0;
        if (bus.enable) begin
          state_n = ST_BLANK;
          timer_n = BLANK_LD;
        end
      end
      ST_BLANK: begin
        if (timer != '0) begin
          timer_n = timer - TW'(1);
        end else if (!any) begin
          timer_n = BLANK_LD;
        end else begin
          state_n = ST_DRIVE;
          idx_n   = nxt;
          timer_n = DWELL_LD;
          seg_n   = ~seg_arr[nxt];
          sel_n   = sel_hot ^ SEL_OFF;
          cur_n   = 3'(nxt);
        end
      end
      ST_DRIVE: begin
        if (timer != '0) begin
          timer_n = timer - TW'(1);
          seg_n   = seg_q;
          sel_n   = sel_q;
          cur_n   = cur_q;
        end else begin
          idx_n = idx_inc;
          fd_n  = ((bus.digit_en >> (int'(idx) + 1)) == '0);
          if (BLANK_CYCLES == 0 && any) begin
            state_n = ST_DRIVE;
            idx_n   = nxt;
            timer_n = DWELL_LD;
            seg_n   = ~seg_arr[nxt];
            sel_n   = sel_hot ^ SEL_OFF;
            cur_n   = 3'(nxt);
          end else begin
            state_n = ST_BLANK;
            timer_n = BLANK_LD;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
    // Disable wins from any state and blanks the display on the next edge.
    if (!bus.enable) begin
      state_n = ST_IDLE;
      idx_n   = '0;
      timer_n = '0;
      seg_n   = SEG_BLANK;
      sel_n   = SEL_OFF;
      cur_n   = '0;
      fd_n    = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= ST_IDLE;
      idx   <= '0;
      timer <= '0;
      seg_q <= SEG_BLANK;
      sel_q <= SEL_OFF;
      cur_q <= '0;
      fd_q  <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      timer <= timer_n;
      seg_q <= seg_n;
      sel_q <= sel_n;
      cur_q <= cur_n;
      fd_q  <= fd_n;
    end
  end

  assign bus.seg_out    = seg_q;
  assign bus.sel        = sel_q;
  assign bus.cur_digit  = cur_q;
  assign bus.frame_done = fd_q;

endmodule
